// File: rtl/apb_burst_master_if.sv
// Command/response and APB bus bundle for apb_burst_master.
// master: the burst engine side. slave: the client and APB slave side.
interface apb_burst_master_if #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8,
  parameter int MAX_BEATS = 4
);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int PW = DATA_BITS * MAX_BEATS;

  // command channel
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [BW-1:0]        cmd_beats;
  logic [PW-1:0]        cmd_wdata;
  // response channel
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [PW-1:0]        rsp_rdata;
  logic                 rsp_error;
  logic                 rsp_timeout;
  logic [BW-1:0]        rsp_beats_done;
  // APB3
  logic [ADDR_BITS-1:0] PADDR;
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [DATA_BITS-1:0] PWDATA;
  logic [DATA_BITS-1:0] PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_beats, cmd_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, rsp_beats_done,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_beats, cmd_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, rsp_beats_done,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_burst_master.sv
// APB3 burst master: accepts one command at a time, runs 1..MAX_BEATS
// auto-incrementing beats with wait states, error abort and wait timeout,
// then holds a packed response until the client takes it.
module apb_burst_master #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8,
  parameter int MAX_BEATS = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic PCLK,
  input  logic reset,
  apb_burst_master_if.master bus
);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int PW = DATA_BITS * MAX_BEATS;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t        r_state;
  logic          r_write;
  logic [BW-1:0] r_nbeats;
  logic [PW-1:0] r_wdata;   // write data still to send; current beat in the low slice
  logic [31:0]   r_wait;    // consecutive PREADY-low ACCESS cycles of this beat

  logic [BW-1:0] w_beats;
  logic [PW-1:0] w_next_wdata;
  logic          w_last;
  logic          w_tmo;
  logic          w_end;

  // Clamp the requested beat count into 1..MAX_BEATS.
  always_comb begin
    w_beats = bus.cmd_beats;
    if (bus.cmd_beats == '0)
      w_beats = BW'(1);
    else if (bus.cmd_beats > BW'(MAX_BEATS))
      w_beats = BW'(MAX_BEATS);
  end

  assign w_next_wdata = r_wdata >> DATA_BITS;
  assign w_last       = (bus.rsp_beats_done + BW'(1)) == r_nbeats;
  assign w_tmo        = (TIMEOUT != 0) && ((r_wait + 32'd1) == 32'(TIMEOUT));
  // burst ends this ACCESS cycle: error, final good beat, or timeout
  assign w_end        = bus.PREADY ? (bus.PSLVERR || w_last) : w_tmo;

  // Single FSM; every output is a register updated on the state transition.
  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      r_state            <= S_IDLE;
      r_write            <= 1'b0;
      r_nbeats           <= '0;
      r_wdata            <= '0;
      r_wait             <= '0;
      bus.cmd_ready      <= 1'b1;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_rdata      <= '0;
      bus.rsp_error      <= 1'b0;
      bus.rsp_timeout    <= 1'b0;
      bus.rsp_beats_done <= '0;
      bus.PADDR          <= '0;
      bus.PSEL           <= 1'b0;
      bus.PENABLE        <= 1'b0;
      bus.PWRITE         <= 1'b0;
      bus.PWDATA         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_write            <= bus.cmd_write;
            r_nbeats           <= w_beats;
            r_wdata            <= bus.cmd_wdata;
            bus.cmd_ready      <= 1'b0;
            bus.rsp_rdata      <= '0;
            bus.rsp_error      <= 1'b0;
            bus.rsp_timeout    <= 1'b0;
            bus.rsp_beats_done <= '0;
            bus.PSEL           <= 1'b1;
            bus.PENABLE        <= 1'b0;
            bus.PADDR          <= bus.cmd_addr;
            bus.PWRITE         <= bus.cmd_write;
            bus.PWDATA         <= bus.cmd_write ? bus.cmd_wdata[DATA_BITS-1:0] : '0;
            r_state            <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_wait      <= '0;
          bus.PENABLE <= 1'b1;
          r_state     <= S_ACCESS;
        end
        S_ACCESS: begin
          // beat outcome
          if (bus.PREADY) begin
            if (bus.PSLVERR)
              bus.rsp_error <= 1'b1;
            else begin
              if (!r_write)
                bus.rsp_rdata[int'(bus.rsp_beats_done)*DATA_BITS +: DATA_BITS] <= bus.PRDATA;
              bus.rsp_beats_done <= bus.rsp_beats_done + BW'(1);
            end
          end else if (w_tmo)
            bus.rsp_timeout <= 1'b1;
          else if (TIMEOUT != 0)
            r_wait <= r_wait + 32'd1;
          // next phase
          if (w_end) begin
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWRITE    <= 1'b0;
            bus.PWDATA    <= '0;
            bus.rsp_valid <= 1'b1;
            r_state       <= S_RESP;
          end else if (bus.PREADY) begin
            // back-to-back beat: PSEL stays high, address wraps modulo 2^ADDR_BITS
            bus.PENABLE <= 1'b0;
            bus.PADDR   <= bus.PADDR + ADDR_BITS'(1);
            bus.PWDATA  <= r_write ? w_next_wdata[DATA_BITS-1:0] : '0;
            r_wdata     <= w_next_wdata;
            r_state     <= S_SETUP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/apb_burst_master.md
Name: apb_burst_master

Overview:
- Synthesizable APB3 master that runs multi-beat little-endian register transfers on behalf of a command/response client. Successor to the simulation-only APB2 tester tasks.
- Adds PREADY wait states, PSLVERR capture, a configurable wait timeout and 1..MAX_BEATS auto-incrementing bursts.
- Sits between FPGA-side control logic (or a testbench driver) and the APB slaves of the test shield.

Parameters:
ADDR_BITS, 4, APB address width.
DATA_BITS, 8, APB data width (one beat).
MAX_BEATS, 4, maximum beats per command; packed data width is DATA_BITS*MAX_BEATS.
TIMEOUT, 16, maximum consecutive ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
PCLK  in  1  clock; all logic on posedge.
reset  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  master can accept a command.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_BITS  address of beat 0.
cmd_beats  in  $clog2(MAX_BEATS+1)  beat count.
cmd_wdata  in  DATA_BITS*MAX_BEATS  write data; beat i in [i*DATA_BITS +: DATA_BITS].
rsp_valid  out  1  response available.
rsp_ready  in  1  client accepts response.
rsp_rdata  out  DATA_BITS*MAX_BEATS  read data, packed like cmd_wdata.
rsp_error  out  1  PSLVERR was seen; burst aborted.
rsp_timeout  out  1  timeout fired; burst aborted.
rsp_beats_done  out  $clog2(MAX_BEATS+1)  beats completed with PREADY=1.
PADDR  out  ADDR_BITS  APB address.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PWDATA  out  DATA_BITS  APB write data.
PRDATA  in  DATA_BITS  APB read data.
PREADY  in  1  slave ready (tie 1 for APB2 slaves).
PSLVERR  in  1  slave error (tie 0 if unused).

Behaviour:
- Reset (async, immediate):
  - State IDLE; all outputs 0; cmd_ready=1.
  - A transfer in flight is dropped mid-beat with no response.
- All outputs are registered. Idle APB outputs are driven 0, never X.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch the command, clear rsp_rdata, beat=0, go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, PADDR=addr+beat, PWRITE=cmd_write, PWDATA=beat slice (0 for reads). Always goes to ACCESS after one cycle.
  - ACCESS: PSEL=1, PENABLE=1, signals held stable.
    - PREADY=1, PSLVERR=0: for reads, store PRDATA into the beat slice; increment the beat count. If the last beat, go to RESP; otherwise go to SETUP (PSEL stays high, back-to-back).
    - PREADY=1, PSLVERR=1: rsp_error=1; beat not counted, read data not stored; go to RESP.
    - PREADY=0: increment the wait counter. When it reaches TIMEOUT (TIMEOUT>0), set rsp_timeout=1 and go to RESP. The wait counter clears at each SETUP.
  - RESP: PSEL=PENABLE=0; rsp_valid=1, response held stable until rsp_ready. On the handshake, go to IDLE.
- cmd_ready=0 in every state except IDLE, so only one command is outstanding.
- cmd_beats clamp: 0 is treated as 1; a value greater than MAX_BEATS is treated as MAX_BEATS.
- Address arithmetic is modulo 2^ADDR_BITS: addr+beat wraps silently, e.g. 0xF then 0x0.
- Latency, no wait states: command accepted at edge T; SETUP in cycle T+1; ACCESS in cycle T+2; rsp_valid high from T+3.
  - An N-beat burst takes 2N cycles on APB.
  - Each wait cycle adds 1.
- rsp_error and rsp_timeout are mutually exclusive. Unfinished beats read back as 0.
- PSLVERR is sampled only when PSEL&&PENABLE&&PREADY.
- If rsp_valid and rsp_ready are both high in the same cycle as cmd_valid, the command is not accepted until the cycle after IDLE is re-entered.

Test Plan:
- Write 0x5A to addr 0x3, beats=1, PREADY=1 -> cycle T+1: PSEL=1, PENABLE=0, PADDR=3, PWDATA=0x5A; cycle T+2: PENABLE=1; rsp_valid at T+3; error=0, timeout=0, beats_done=1.
- Read, beats=4, addr 0x2, slave returns 0x11,0x22,0x33,0x44 -> PADDR sequence 2,3,4,5; PSEL held high for 8 cycles; rsp_rdata=0x44332211.
- Write, beats=2, addr 0xF, PREADY low for 3 cycles on beat 0 -> PADDR 0xF then 0x0; PADDR/PWDATA stable during waits; response 3 cycles later than with no waits.
- Read, beats=4, PSLVERR=1 on beat 1 -> no SETUP for beat 2; rsp_error=1, beats_done=1, rsp_rdata upper 24 bits = 0.
- TIMEOUT=16, PREADY held 0 -> after 16 ACCESS cycles, rsp_timeout=1 and PSEL=0; next command completes normally. With TIMEOUT=0 the transfer waits indefinitely.
- Assert reset during ACCESS of beat 2; deassert; issue beats=0 -> APB outputs go 0 at once, no rsp_valid; next command runs exactly 1 beat; rsp_ready held low keeps rsp_valid=1 and cmd_ready=0.
